// File: rtl/saddr_next_range_pkg.sv
// Shared constants and helpers for the next-line address / security range block.
package saddr_next_range_pkg;

    localparam int unsigned ADDR_W = 65;
    localparam int unsigned VA_TOP = 43;
    localparam int unsigned NEXT_W = 15;
    localparam int unsigned PAGE_W = 14;
    localparam int unsigned LOW_W  = 11;
    localparam int unsigned HIGH_W = NEXT_W - LOW_W;
    localparam int unsigned INC_W  = VA_TOP - LOW_W + 1;
    localparam int unsigned HI_W   = ADDR_W - VA_TOP;

    localparam logic [NEXT_W-1:0] LINE_STEP = 15'h0080;

    // hi = addr[64:43]; canonical when the tag is clear and [63:43] is uniform
    function automatic logic is_canonical(input logic [HI_W-1:0] hi);
        return ~hi[HI_W-1] & ((&hi[HI_W-2:0]) | ~(|hi[HI_W-2:0]));
    endfunction

endpackage

// File: rtl/saddr_next_range_if.sv
// Operand and result bundle between the address-generation stage and this block.
interface saddr_next_range_if;
    import saddr_next_range_pkg::*;

    logic                in_en;
    logic [ADDR_W-1:0]   cmplx_addr;
    logic                cin_secq;
    logic                ptrdiff;
    logic                split;

    logic                out_en;
    logic [NEXT_W-1:0]   addr_next;
    logic [ADDR_W-1:0]   addr_overreach;
    logic                cout_secq;
    logic                fault_cann;

    modport master (
        output in_en, cmplx_addr, cin_secq, ptrdiff, split,
        input  out_en, addr_next, addr_overreach, cout_secq, fault_cann
    );

    modport slave (
        input  in_en, cmplx_addr, cin_secq, ptrdiff, split,
        output out_en, addr_next, addr_overreach, cout_secq, fault_cann
    );

endinterface

// File: rtl/saddr_next_range_adder_15_11.sv
// 15-bit adder that also exposes the carry from bit 10 into bit 11.
module adder_15_11
    import saddr_next_range_pkg::*;
(
    input  logic [NEXT_W-1:0] a,
    input  logic [NEXT_W-1:0] b,
    output logic [NEXT_W-1:0] sum_c,
    output logic              c11_c
);

    logic [LOW_W:0]    low_c;
    logic [HIGH_W-1:0] high_c;

    assign low_c  = {1'b0, a[LOW_W-1:0]} + {1'b0, b[LOW_W-1:0]};
    assign c11_c  = low_c[LOW_W];
    assign high_c = a[NEXT_W-1:LOW_W] + b[NEXT_W-1:LOW_W] + HIGH_W'(low_c[LOW_W]);
    assign sum_c  = {high_c, low_c[LOW_W-1:0]};

endmodule

// File: rtl/saddr_next_range_adder_inc.sv
// Carry-in incrementer; the carry out is dropped so the result wraps.
module adder_inc #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic         cin,
    output logic [W-1:0] y_c
);

    assign y_c = a + W'(cin);

endmodule

// File: rtl/saddr_next_range_range.sv
// Pointer-security range check on the upper address bits [64:43].
module addrcalcsec_range
    import saddr_next_range_pkg::*;
(
    input  logic [HI_W-1:0] addr_hi,
    input  logic            cin_secq,
    input  logic            ptrdiff,
    output logic            ok_c
);

    assign ok_c = cin_secq & (ptrdiff | is_canonical(addr_hi));

endmodule

// File: rtl/saddr_next_range.sv
// Next-line address generation with canonical-range security check, one register stage.
module saddr_next_range
    import saddr_next_range_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    saddr_next_range_if.slave  bus
);

    logic [NEXT_W-1:0] sum_c;
    logic              coov_c;
    logic [INC_W-1:0]  inc_c;
    logic [ADDR_W-1:0] overreach_c;
    logic              r1_c;
    logic              r2_c;
    logic              secq_c;

    adder_15_11 u_add (
        .a     ({1'b0, bus.cmplx_addr[PAGE_W-1:0]}),
        .b     (LINE_STEP),
        .sum_c (sum_c),
        .c11_c (coov_c)
    );

    adder_inc #(.W(INC_W)) u_inc (
        .a   (bus.cmplx_addr[VA_TOP:LOW_W]),
        .cin (coov_c),
        .y_c (inc_c)
    );

    // Tag and bits above the VA stay untouched; only [43:0] advances
    assign overreach_c = {bus.cmplx_addr[ADDR_W-1:VA_TOP+1], inc_c, sum_c[LOW_W-1:0]};

    addrcalcsec_range u_r1 (
        .addr_hi  (bus.cmplx_addr[ADDR_W-1:VA_TOP]),
        .cin_secq (bus.cin_secq),
        .ptrdiff  (bus.ptrdiff),
        .ok_c     (r1_c)
    );

    addrcalcsec_range u_r2 (
        .addr_hi  (overreach_c[ADDR_W-1:VA_TOP]),
        .cin_secq (bus.cin_secq),
        .ptrdiff  (bus.ptrdiff),
        .ok_c     (r2_c)
    );

    // The next-line address only matters when the access actually spills into it
    assign secq_c = r1_c & (r2_c | ~bus.split);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_en         <= 1'b0;
            bus.addr_next      <= '0;
            bus.addr_overreach <= '0;
            bus.cout_secq      <= 1'b0;
            bus.fault_cann     <= 1'b0;
        end else begin
            bus.out_en         <= bus.in_en;
            bus.addr_next      <= sum_c;
            bus.addr_overreach <= overreach_c;
            bus.cout_secq      <= secq_c;
            bus.fault_cann     <= bus.in_en & ~secq_c;
        end
    end

endmodule

// File: tb/tb_saddr_next_range.sv
// Self-checking bench: directed corner cases plus random operands against an arithmetic model.
module tb_saddr_next_range;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    saddr_next_range_if bus ();

    saddr_next_range dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] m_next(input logic [64:0] a);
        return 15'(a[13:0]) + 15'd128;
    endfunction

    function automatic logic [64:0] m_over(input logic [64:0] a);
        logic [43:0] lo;
        lo = a[43:0] + 44'h80;
        return {a[64:44], lo};
    endfunction

    function automatic logic m_canon(input logic [64:0] a);
        logic [21:0] hi;
        hi = a[64:43];
        return (hi == 22'h0) || (hi == 22'h1F_FFFF);
    endfunction

    function automatic logic m_secq(input logic [64:0] a, input logic cin, input logic pd,
                                    input logic sp);
        logic r1;
        logic r2;
        r1 = cin && (pd || m_canon(a));
        r2 = cin && (pd || m_canon(m_over(a)));
        return r1 && (r2 || !sp);
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [64:0] a, input logic cin,
                         input logic pd, input logic sp);
        bus.in_en      = en;
        bus.cmplx_addr = a;
        bus.cin_secq   = cin;
        bus.ptrdiff    = pd;
        bus.split      = sp;
    endtask

    task automatic check_model(input string tag);
        logic s;
        s = m_secq(bus.cmplx_addr, bus.cin_secq, bus.ptrdiff, bus.split);
        chk({tag, ".out_en"},    65'(bus.out_en),         65'(bus.in_en));
        chk({tag, ".next"},      65'(bus.addr_next),      65'(m_next(bus.cmplx_addr)));
        chk({tag, ".over"},      bus.addr_overreach,      m_over(bus.cmplx_addr));
        chk({tag, ".secq"},      65'(bus.cout_secq),      65'(s));
        chk({tag, ".fault"},     65'(bus.fault_cann),     65'(bus.in_en & ~s));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".out_en"}, 65'(bus.out_en),     65'd0);
        chk({tag, ".next"},   65'(bus.addr_next),  65'd0);
        chk({tag, ".over"},   bus.addr_overreach,  65'd0);
        chk({tag, ".secq"},   65'(bus.cout_secq),  65'd0);
        chk({tag, ".fault"},  65'(bus.fault_cann), 65'd0);
    endtask

    // Apply inputs, clock once, then sample just after the edge
    task automatic step(input string tag, input logic en, input logic [64:0] a,
                        input logic cin, input logic pd, input logic sp);
        drive(en, a, cin, pd, sp);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [64:0] a;
        logic [63:0] r;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(1'b1, 65'h1_2345_6789_ABCD_EF00, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // 0x0F80 + 0x80 carries into bit 11 and increments [43:11]
        a = {51'h0, 14'h0F80};
        step("d032", 1'b1, a, 1'b1, 1'b0, 1'b1);
        chk("d032.next_k", 65'(bus.addr_next), 65'h1000);
        chk("d032.hi_k",   65'(bus.addr_overreach[43:11]), 65'(a[43:11]) + 65'd1);
        chk("d032.secq_k", 65'(bus.cout_secq), 65'd1);

        a = {51'h0, 14'h3F80};
        step("d033", 1'b1, a, 1'b1, 1'b0, 1'b0);
        chk("d033.next_k", 65'(bus.addr_next), 65'h4000);

        a = {51'h0, 14'h0010};
        step("d034", 1'b1, a, 1'b1, 1'b0, 1'b1);
        chk("d034.next_k", 65'(bus.addr_next), 65'h0090);
        chk("d034.hi_k",   65'(bus.addr_overreach[43:11]), 65'(a[43:11]));

        a = {1'b0, 21'h10_0000, 43'h123};
        step("d035a", 1'b1, a, 1'b1, 1'b0, 1'b0);
        chk("d035a.secq_k",  65'(bus.cout_secq),  65'd0);
        chk("d035a.fault_k", 65'(bus.fault_cann), 65'd1);
        step("d035b", 1'b1, a, 1'b1, 1'b1, 1'b0);
        chk("d035b.secq_k",  65'(bus.cout_secq),  65'd1);

        a = {21'h0, 44'h7FF_FFFF_FFC0};
        step("d036a", 1'b1, a, 1'b1, 1'b0, 1'b1);
        chk("d036a.b43_k",  65'(bus.addr_overreach[43]), 65'd1);
        chk("d036a.secq_k", 65'(bus.cout_secq), 65'd0);
        step("d036b", 1'b1, a, 1'b1, 1'b0, 1'b0);
        chk("d036b.secq_k", 65'(bus.cout_secq), 65'd1);

        // Tag bit set, untrusted input, and idle cycle
        step("tag", 1'b1, {1'b1, 64'h0}, 1'b1, 1'b0, 1'b0);
        step("untrusted", 1'b1, 65'h40, 1'b0, 1'b1, 1'b0);
        step("idle", 1'b0, 65'h40, 1'b0, 1'b0, 1'b0);

        // Mid-cycle reset clears loaded results without waiting for an edge
        step("pre_rst", 1'b1, {51'h0, 14'h0F80}, 1'b1, 1'b0, 1'b1);
        drive(1'b1, {22'h0, 43'h7FF_FFFF_FF90}, 1'b1, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("held_rst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_model("post_rst");

        // Random operands biased towards canonical edges and line crossings
        for (int i = 0; i < 300; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: a = {22'h0, r[42:0]};
                1: a = {1'b0, 21'h1F_FFFF, r[42:0]};
                2: a = {22'h0, 35'h7_FFFF_FFFF, r[7:0]};
                default: a = {1'($urandom), r};
            endcase
            step("rand", 1'($urandom), a, 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/saddr_next_range.md
SADDR_NEXT_RANGE -- requirements
Module: saddr_next_range

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous, active-high; ports named clk and rst as elsewhere in the codebase.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 in_en  in  1  operand valid this cycle.
REQ-005 cmplx_addr  in  65  computed access address; [64] is the non-pointer tag, [63:0] is the virtual address.
REQ-006 cin_secq  in  1  incoming pointer-security qualifier (1 = trusted).
REQ-007 ptrdiff  in  1  pointer-difference op; bypasses the canonical check.
REQ-008 split  in  1  access spans into the next 128-byte line.
REQ-009 out_en  out  1  registered in_en.
REQ-010 addr_next  out  15  registered {0,cmplx_addr[13:0]} + 0x80; [14] = 16 KB page crossing.
REQ-011 addr_overreach  out  65  registered next-line address.
REQ-012 cout_secq  out  1  registered combined security result.
REQ-013 fault_cann  out  1  registered ~cout_secq qualified by in_en.

Function
REQ-014 Next-line adder SHALL compute a 15-bit sum = {1'b0,cmplx_addr[13:0]} + 15'h0080, modulo 2^15.
REQ-015 coov SHALL be the carry out of sum bits [10:0] into bit 11, i.e. (cmplx_addr[10:0] + 11'h080) >= 2^11.
REQ-016 Incrementer SHALL produce cmplx_addr[43:11] + coov as a 33-bit result; its carry out is discarded (wraps at 2^44).
REQ-017 Overreach SHALL be: [10:0] = sum[10:0]; [43:11] = incrementer result; [64:44] = cmplx_addr[64:44] unchanged.
REQ-018 Range checker: a 65-bit address is canonical when bits [63:43] are all 0 or all 1, and bit [64] = 0.
REQ-019 Range result SHALL be cin_secq & (ptrdiff | canonical).
REQ-020 Two range-checker instances SHALL run, one on cmplx_addr (r1) and one on overreach (r2).
REQ-021 cout_secq SHALL be r1 & (r2 | ~split).
REQ-022 fault_cann SHALL be in_en & ~cout_secq.
REQ-023 Latency: all datapath logic combinational, one register stage; outputs valid the cycle after in_en.
REQ-024 Output registers SHALL load every cycle regardless of in_en; no stall or handshake.
REQ-025 Back-to-back inputs SHALL be accepted every cycle.

Reset
REQ-026 During rst, all outputs SHALL be 0: out_en, addr_next, addr_overreach, cout_secq, fault_cann.
REQ-027 Reset asserted mid-operation SHALL clear an in-flight result immediately (asynchronously).
REQ-028 The first cycle after reset release SHALL register the current inputs normally.

Structure
REQ-029 Shared package SHALL hold constants LINE_STEP = 15'h0080, VA_TOP = 43, ADDR_W = 65.
REQ-030 Sub-modules: adder_15_11 (15-bit adder with bit-11 carry out), adder_inc (parameterised width, default 33), addrcalcsec_range (combinational).
REQ-031 addrcalcsec_range is the one natural reusable sub-module and SHALL be instantiated twice.

Verification
REQ-032 cmplx_addr[13:0]=14'h0F80, upper bits 0, cin_secq=1, split=1 -> addr_next=15'h1000, coov=1, addr_overreach[43:11]=cmplx_addr[43:11]+1, cout_secq=1.
REQ-033 cmplx_addr[13:0]=14'h3F80 -> addr_next=15'h4000 (bit 14 set).
REQ-034 cmplx_addr[13:0]=14'h0010 -> addr_next=15'h0090, coov=0, overreach[43:11] unchanged.
REQ-035 cmplx_addr[63:43]=21'h100000, cin_secq=1, ptrdiff=0, in_en=1 -> cout_secq=0, fault_cann=1; same input with ptrdiff=1 -> cout_secq=1.
REQ-036 cmplx_addr=44'h7FF_FFFF_FFC0 (upper bits 0), cin_secq=1: split=1 -> overreach[43]=1 (non-canonical), cout_secq=0; split=0 -> cout_secq=1.
REQ-037 Assert rst during a valid cycle -> all outputs 0 at once; after release, the next input appears one cycle later.
